// File: rtl/fu_wb_pkg.sv
// Shared types for the FU writeback arbiter: the buffered result bundle and
// the FU index width helper.
package fu_wb_pkg;

    localparam int WB_NUM_FU       = 4;
    localparam int WB_INST_ID_BITS = 6;
    localparam int WB_PRN_BITS     = 6;
    localparam int WB_MAX_OPERANDS = 3;
    localparam int WB_DATA_BITS    = 64;

    // we is pre-reduced to prn_valid & data_valid at enqueue time
    typedef struct packed {
        logic [WB_INST_ID_BITS-1:0]                     inst_id;
        logic [WB_MAX_OPERANDS-1:0][WB_PRN_BITS-1:0]    prn;
        logic [WB_MAX_OPERANDS-1:0]                     we;
        logic [WB_MAX_OPERANDS-1:0][WB_DATA_BITS-1:0]   data;
    } wb_entry_t;

    function automatic int fu_idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-FU result buffer. A push into a full buffer is taken only when the
// head pops in the same cycle, so the FU never has to be stalled.
module wb_fifo
    import fu_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  wb_entry_t                 din,
    output wb_entry_t                 head,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              push_ok, pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

    // Storage needs no reset: count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Buffers FU results and broadcasts one completion per cycle to the
// writeback bus, round-robin across FUs, with a grant lock under backpressure.
module fu_wb_arbiter
    import fu_wb_pkg::*;
#(
    parameter int NUM_FU      = WB_NUM_FU,
    parameter int DEPTH       = 4,
    parameter int HOLD_MARGIN = 2,
    localparam int IDX_W      = fu_idx_bits(NUM_FU)
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [NUM_FU-1:0]                                     fu_out_valid,
    input  logic [NUM_FU-1:0][WB_INST_ID_BITS-1:0]                fu_out_inst_id,
    input  logic [NUM_FU-1:0][WB_MAX_OPERANDS-1:0][WB_PRN_BITS-1:0] fu_out_prn,
    input  logic [NUM_FU-1:0][WB_MAX_OPERANDS-1:0]                fu_out_prn_valid,
    input  logic [NUM_FU-1:0][WB_MAX_OPERANDS-1:0][WB_DATA_BITS-1:0] fu_out_data,
    input  logic [NUM_FU-1:0][WB_MAX_OPERANDS-1:0]                fu_out_data_valid,
    input  logic                                                  wb_ready,
    output logic                                                  wb_valid,
    output logic [IDX_W-1:0]                                      wb_fu_idx,
    output logic [WB_INST_ID_BITS-1:0]                            wb_inst_id,
    output logic [WB_MAX_OPERANDS-1:0][WB_PRN_BITS-1:0]           wb_prn,
    output logic [WB_MAX_OPERANDS-1:0]                            wb_we,
    output logic [WB_MAX_OPERANDS-1:0][WB_DATA_BITS-1:0]          wb_data,
    output logic [NUM_FU-1:0]                                     fu_hold,
    output logic                                                  overflow_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t                   din  [NUM_FU];
    wb_entry_t                   head [NUM_FU];
    logic [NUM_FU-1:0]           push, pop, full, empty;
    logic [NUM_FU-1:0][CW-1:0]   count;

    logic [IDX_W-1:0]            rr_ptr, lock_idx, grant, cand;
    logic                        locked, found, xfer;
    wb_entry_t                   gh;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
        assign din[g] = '{inst_id: fu_out_inst_id[g],
                          prn:     fu_out_prn[g],
                          we:      fu_out_prn_valid[g] & fu_out_data_valid[g],
                          data:    fu_out_data[g]};

        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (din[g]),
            .head  (head[g]),
            .count (count[g]),
            .full  (full[g]),
            .empty (empty[g])
        );

        assign fu_hold[g] = (DEPTH - int'(count[g])) <= HOLD_MARGIN;
    end

    // First non-empty buffer at or after the pointer; a held grant overrides
    always_comb begin
        grant = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_FU);
            if (!found && !empty[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
        if (locked) grant = lock_idx;
    end

    // A locked grant always points at a non-empty buffer: it cannot pop untransferred
    assign wb_valid = locked || found;
    assign xfer     = wb_valid && wb_ready;
    assign pop      = xfer ? (NUM_FU'(1) << grant) : '0;
    assign push     = fu_out_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= '0;
            locked       <= 1'b0;
            lock_idx     <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (xfer) begin
                rr_ptr <= (grant == IDX_W'(NUM_FU-1)) ? '0 : grant + IDX_W'(1);
                locked <= 1'b0;
            end else if (wb_valid) begin
                locked   <= 1'b1;
                lock_idx <= grant;
            end
            if (|(push & full & ~pop)) overflow_err <= 1'b1;
        end
    end

    assign gh         = head[grant];
    assign wb_fu_idx  = wb_valid ? grant      : '0;
    assign wb_inst_id = wb_valid ? gh.inst_id : '0;
    assign wb_prn     = wb_valid ? gh.prn     : '0;
    assign wb_we      = wb_valid ? gh.we      : '0;
    assign wb_data    = wb_valid ? gh.data    : '0;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed bench for fu_wb_arbiter: a queue-based model of per-FU buffers and
// round-robin writeback, checked every cycle, plus literal spot expectations.
module tb_fu_wb_arbiter;
    import fu_wb_pkg::*;

    localparam int NF    = WB_NUM_FU;
    localparam int MO    = WB_MAX_OPERANDS;
    localparam int DEPTH = 4;
    localparam int HM    = 2;
    localparam int IW    = fu_idx_bits(NF);

    logic clk = 1'b0;
    logic rst;
    logic [NF-1:0]                              fu_out_valid;
    logic [NF-1:0][WB_INST_ID_BITS-1:0]         fu_out_inst_id;
    logic [NF-1:0][MO-1:0][WB_PRN_BITS-1:0]     fu_out_prn;
    logic [NF-1:0][MO-1:0]                      fu_out_prn_valid;
    logic [NF-1:0][MO-1:0][WB_DATA_BITS-1:0]    fu_out_data;
    logic [NF-1:0][MO-1:0]                      fu_out_data_valid;
    logic                                       wb_ready;
    logic                                       wb_valid;
    logic [IW-1:0]                              wb_fu_idx;
    logic [WB_INST_ID_BITS-1:0]                 wb_inst_id;
    logic [MO-1:0][WB_PRN_BITS-1:0]             wb_prn;
    logic [MO-1:0]                              wb_we;
    logic [MO-1:0][WB_DATA_BITS-1:0]            wb_data;
    logic [NF-1:0]                              fu_hold;
    logic                                       overflow_err;

    fu_wb_arbiter #(.NUM_FU(NF), .DEPTH(DEPTH), .HOLD_MARGIN(HM)) dut (
        .clk               (clk),
        .rst               (rst),
        .fu_out_valid      (fu_out_valid),
        .fu_out_inst_id    (fu_out_inst_id),
        .fu_out_prn        (fu_out_prn),
        .fu_out_prn_valid  (fu_out_prn_valid),
        .fu_out_data       (fu_out_data),
        .fu_out_data_valid (fu_out_data_valid),
        .wb_ready          (wb_ready),
        .wb_valid          (wb_valid),
        .wb_fu_idx         (wb_fu_idx),
        .wb_inst_id        (wb_inst_id),
        .wb_prn            (wb_prn),
        .wb_we             (wb_we),
        .wb_data           (wb_data),
        .fu_hold           (fu_hold),
        .overflow_err      (overflow_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: one queue per FU, the next-FU pointer, and the held grant
    wb_entry_t mq [NF][$];
    int        m_ptr  = 0;
    bit        m_lock = 0;
    int        m_lidx = 0;
    bit        m_ovf  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_grant();
        if (m_lock) return m_lidx;
        for (int k = 0; k < NF; k++)
            if (mq[(m_ptr + k) % NF].size() > 0) return (m_ptr + k) % NF;
        return -1;
    endfunction

    task automatic model_step();
        int g;
        bit x;
        if (!rst) begin
            for (int i = 0; i < NF; i++) mq[i].delete();
            m_ptr = 0; m_lock = 0; m_ovf = 0;
            return;
        end
        g = m_grant();
        x = (g >= 0) && wb_ready;
        for (int i = 0; i < NF; i++) begin
            int  sz;
            bit  p;
            wb_entry_t e;
            sz = mq[i].size();
            p  = x && (g == i);
            if (p) void'(mq[i].pop_front());
            if (fu_out_valid[i]) begin
                e.inst_id = fu_out_inst_id[i];
                e.prn     = fu_out_prn[i];
                e.we      = fu_out_prn_valid[i] & fu_out_data_valid[i];
                e.data    = fu_out_data[i];
                if (sz < DEPTH || p) mq[i].push_back(e);
                else m_ovf = 1;
            end
        end
        if (x) begin
            m_ptr  = (g + 1) % NF;
            m_lock = 0;
        end else if (g >= 0) begin
            m_lock = 1;
            m_lidx = g;
        end
    endtask

    task automatic check_outputs();
        int g;
        logic [NF-1:0] eh;
        wb_entry_t h;
        g = m_grant();
        chk("wb_valid", wb_valid, g >= 0);
        if (g >= 0) begin
            h = mq[g][0];
            chk("wb_fu_idx",  wb_fu_idx,  g);
            chk("wb_inst_id", wb_inst_id, h.inst_id);
            chk("wb_prn",     wb_prn,     h.prn);
            chk("wb_we",      wb_we,      h.we);
            chk("wb_data",    wb_data,    h.data);
        end else begin
            chk("wb_idle_zero", {wb_inst_id, wb_prn, wb_we, wb_data}, '0);
        end
        for (int i = 0; i < NF; i++) eh[i] = (DEPTH - mq[i].size()) <= HM;
        chk("fu_hold", fu_hold, eh);
        chk("overflow_err", overflow_err, m_ovf);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clr_all();
        fu_out_valid      = '0;
        fu_out_inst_id    = '0;
        fu_out_prn        = '0;
        fu_out_prn_valid  = '0;
        fu_out_data       = '0;
        fu_out_data_valid = '0;
    endtask

    task automatic set_fu(input int i, input int id);
        fu_out_valid[i]   = 1'b1;
        fu_out_inst_id[i] = WB_INST_ID_BITS'(id);
        for (int k = 0; k < MO; k++) begin
            fu_out_prn[i][k]        = WB_PRN_BITS'(id + 7*k + i);
            fu_out_prn_valid[i][k]  = 1'((id >> k) & 1);
            fu_out_data_valid[i][k] = ((id + k) % 3) != 0;
            fu_out_data[i][k]       = {16'hA000 | 16'(i), 16'(k), 32'(id)};
        end
    endtask

    task automatic do_reset();
        clr_all();
        wb_ready = 1'b0;
        rst = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        wb_ready = 1'b0;
        clr_all();

        // Reset state
        cycle();
        cycle();
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_fu_hold", fu_hold, '0);
        chk("rst_overflow", overflow_err, 1'b0);
        rst = 1'b1;

        // Single FU latency, no input-to-output bypass
        do_reset();
        fu_out_valid[1] = 1'b1;
        fu_out_inst_id[1] = 6'd5;
        fu_out_prn[1][0] = 6'd12;
        fu_out_prn_valid[1] = 3'b001;
        fu_out_data[1][0] = 64'hDEAD;
        fu_out_data_valid[1] = 3'b001;
        wb_ready = 1'b1;
        #1 chk("no_bypass", wb_valid, 1'b0);
        cycle();
        chk("lat_valid", wb_valid, 1'b1);
        chk("lat_idx", wb_fu_idx, 2'd1);
        chk("lat_inst", wb_inst_id, 6'd5);
        chk("lat_prn0", wb_prn[0], 6'd12);
        chk("lat_we", wb_we, 3'b001);
        chk("lat_data0", wb_data[0], 64'hDEAD);
        clr_all();
        cycle();
        chk("lat_done", wb_valid, 1'b0);

        // Round robin FU0, FU2, FU3 then wrap to FU0
        do_reset();
        wb_ready = 1'b1;
        set_fu(0, 1); set_fu(2, 2); set_fu(3, 3);
        cycle();
        chk("rr_g0", wb_fu_idx, 2'd0);
        clr_all();
        cycle();
        chk("rr_g2", wb_fu_idx, 2'd2);
        cycle();
        chk("rr_g3", wb_fu_idx, 2'd3);
        set_fu(0, 4); set_fu(3, 5);
        cycle();
        chk("rr_wrap_g0", wb_fu_idx, 2'd0);
        chk("rr_wrap_inst", wb_inst_id, 6'd4);
        clr_all();
        cycle();
        chk("rr_wrap_g3", wb_fu_idx, 2'd3);
        cycle();
        chk("rr_empty", wb_valid, 1'b0);

        // Backpressure lock: FU1 arrives behind a held FU2 grant
        do_reset();
        set_fu(2, 40);
        cycle();
        clr_all();
        set_fu(1, 41);
        cycle();
        clr_all();
        chk("bp_idx_a", wb_fu_idx, 2'd2);
        chk("bp_inst_a", wb_inst_id, 6'd40);
        cycle();
        cycle();
        chk("bp_idx_c", wb_fu_idx, 2'd2);
        chk("bp_inst_c", wb_inst_id, 6'd40);
        wb_ready = 1'b1;
        #1 chk("bp_pre_xfer", wb_fu_idx, 2'd2);
        cycle();
        chk("bp_fu1_idx", wb_fu_idx, 2'd1);
        chk("bp_fu1_inst", wb_inst_id, 6'd41);
        cycle();
        chk("bp_drained", wb_valid, 1'b0);

        // Hold and overflow
        do_reset();
        for (int n = 0; n < 5; n++) begin
            set_fu(0, 10 + n);
            cycle();
            clr_all();
            if (n == 0) chk("hold_after_1", fu_hold[0], 1'b0);
            if (n == 1) chk("hold_after_2", fu_hold[0], 1'b1);
        end
        chk("ovf_set", overflow_err, 1'b1);
        wb_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            chk("ovf_drain_inst", wb_inst_id, 6'(10 + n));
            cycle();
        end
        chk("ovf_drain_done", wb_valid, 1'b0);
        chk("ovf_sticky", overflow_err, 1'b1);

        // Full buffer accepts a push alongside its own dequeue
        do_reset();
        for (int n = 0; n < 4; n++) begin
            set_fu(0, 20 + n);
            cycle();
            clr_all();
        end
        chk("full_hold", fu_hold[0], 1'b1);
        wb_ready = 1'b1;
        set_fu(0, 24);
        cycle();
        clr_all();
        chk("full_no_ovf", overflow_err, 1'b0);
        chk("full_still_held", fu_hold[0], 1'b1);
        for (int n = 0; n < 4; n++) begin
            chk("full_drain_inst", wb_inst_id, 6'(21 + n));
            cycle();
        end
        chk("full_drained", wb_valid, 1'b0);

        // Mixed traffic across all FUs with intermittent backpressure
        do_reset();
        for (int c = 0; c < 60; c++) begin
            clr_all();
            for (int i = 0; i < NF; i++)
                if (((c * (i + 3) + i) % 4) == 0) set_fu(i, (c * 4 + i) & 63);
            wb_ready = ((c % 5) != 1) && ((c % 7) != 3);
            cycle();
        end
        clr_all();
        wb_ready = 1'b1;
        for (int c = 0; c < 20; c++) cycle();

        // Asynchronous reset with buffered traffic
        do_reset();
        for (int n = 0; n < 3; n++) begin
            set_fu(0, 30 + n);
            cycle();
            clr_all();
        end
        chk("pre_rst_hold", fu_hold[0], 1'b1);
        #2 rst = 1'b0;
        #1 chk("async_wb_valid", wb_valid, 1'b0);
        chk("async_fu_hold", fu_hold, '0);
        cycle();
        #2 rst = 1'b1;
        wb_ready = 1'b1;
        for (int n = 0; n < 3; n++) cycle();
        chk("post_rst_no_stale", wb_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
